bcd_serial_adder: RTL and testbench



---
 rtl/bcd_pkg.sv | 19 +
 rtl/bcd_digit_add.sv | 25 ++
 rtl/bcd_serial_adder.sv | 135 +++++++++++++
 tb/tb_bcd_serial_adder.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder/subtractor.
//   DIGIT_W    : bits per BCD digit
//   BCD_MAX    : largest legal digit value
//   BCD_CORR   : decimal-adjust constant added when a digit sum exceeds 9
//   state_t    : sequencer states (IDLE, RUN)
//   nines_comp : 9's complement of one digit (wraps for illegal digits)
package bcd_pkg;

  localparam int         DIGIT_W  = 4;
  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [3:0] BCD_CORR = 4'd6;

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [DIGIT_W-1:0] nines_comp(input logic [DIGIT_W-1:0] digit);
    return BCD_MAX - digit;
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder cell.
//   i_a, i_b : BCD digits
//   i_cin    : carry in
//   o_sum    : decimal-adjusted digit
//   o_cout   : decimal carry out (raw sum > 9)
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_a,
  input  logic [DIGIT_W-1:0] i_b,
  input  logic               i_cin,
  output logic [DIGIT_W-1:0] o_sum,
  output logic               o_cout
);

  logic [DIGIT_W:0]   w_raw;
  logic [DIGIT_W-1:0] w_adj;

  assign w_raw  = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT_W{1'b0}}, i_cin};
  // Only the low nibble of raw+6 is kept, so a 4-bit add gives the same digit.
  assign w_adj  = w_raw[DIGIT_W-1:0] + BCD_CORR;
  assign o_cout = (w_raw > {1'b0, BCD_MAX});
  assign o_sum  = o_cout ? w_adj : w_raw[DIGIT_W-1:0];

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit BCD adder/subtractor, one digit per clock, LSD first.
//   clk, rst  : clock, asynchronous active-high reset
//   start     : request, sampled only while idle
//   mode_sub  : 0 = a+b+cin, 1 = a-b-cin (cin is borrow-in)
//   a, b      : packed BCD operands, digit 0 in [3:0]
//   cin       : carry/borrow in
//   busy      : operation in progress
//   done      : one-cycle pulse, sum/cout valid
//   sum       : packed BCD result
//   cout      : add: carry out; sub: 1 = no borrow
//   invalid   : a latched operand digit was > 9
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    mode_sub,
  input  logic [4*DIGITS-1:0]     a,
  input  logic [4*DIGITS-1:0]     b,
  input  logic                    cin,
  output logic                    busy,
  output logic                    done,
  output logic [4*DIGITS-1:0]     sum,
  output logic                    cout,
  output logic                    invalid
);

  localparam int W     = DIGIT_W * DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_sum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_invalid;
  logic             r_busy;
  logic             r_done;

  logic [W-1:0]       w_b_eff;
  logic               w_invalid;
  logic               w_accept;
  logic               w_last;
  logic [DIGIT_W-1:0] w_a_dig;
  logic [DIGIT_W-1:0] w_b_dig;
  logic [DIGIT_W-1:0] w_sum_dig;
  logic               w_carry_dig;

  // Subtraction is a + (9's complement of b) + ~borrow: the 10's-complement form.
  always_comb begin
    w_b_eff   = b;
    w_invalid = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (mode_sub) w_b_eff[i*DIGIT_W +: DIGIT_W] = nines_comp(b[i*DIGIT_W +: DIGIT_W]);
      if ((a[i*DIGIT_W +: DIGIT_W] > BCD_MAX) || (b[i*DIGIT_W +: DIGIT_W] > BCD_MAX))
        w_invalid = 1'b1;
    end
  end

  assign w_accept = (r_state == IDLE) && start;
  assign w_last   = (r_idx == IDX_W'(DIGITS - 1));
  assign w_a_dig  = r_a[r_idx*DIGIT_W +: DIGIT_W];
  assign w_b_dig  = r_b[r_idx*DIGIT_W +: DIGIT_W];

  // One cell reused for every digit position, selected by r_idx.
  bcd_digit_add u_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_cin  (r_carry),
    .o_sum  (w_sum_dig),
    .o_cout (w_carry_dig)
  );

  // Operand latches carry no control meaning, so they are not reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= w_b_eff;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_carry   <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_invalid <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_carry   <= mode_sub ? ~cin : cin;
            r_sum     <= '0;
            r_cout    <= 1'b0;
            r_invalid <= w_invalid;
            r_busy    <= 1'b1;
            r_idx     <= '0;
            r_state   <= RUN;
          end
        end
        RUN: begin
          r_sum[r_idx*DIGIT_W +: DIGIT_W] <= w_sum_dig;
          r_carry <= w_carry_dig;
          if (w_last) begin
            r_cout  <= w_carry_dig;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_idx   <= '0;
            r_state <= IDLE;
          end else begin
            r_idx <= r_idx + IDX_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign sum     = r_sum;
  assign cout    = r_cout;
  assign invalid = r_invalid;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

  localparam int D   = 4;
  localparam int W   = 4 * D;
  localparam int MOD = 10 ** D;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         mode_sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         invalid;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .mode_sub (mode_sub),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .cout     (cout),
    .invalid  (invalid)
  );

  // ---------------- reference model (decimal arithmetic) ----------------
  function automatic int bcd2int(input logic [W-1:0] v);
    int r = 0;
    for (int i = D - 1; i >= 0; i--) r = r * 10 + int'(v[i*4 +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int n);
    logic [W-1:0] r = '0;
    int m = n;
    for (int i = 0; i < D; i++) begin
      r[i*4 +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r = '0;
    for (int i = 0; i < D; i++) r[i*4 +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  function automatic logic any_bad_digit(input logic [W-1:0] x, input logic [W-1:0] y);
    logic r = 1'b0;
    for (int i = 0; i < D; i++) if (x[i*4 +: 4] > 4'd9 || y[i*4 +: 4] > 4'd9) r = 1'b1;
    return r;
  endfunction

  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic msub,
                       input logic mcin, output logic [W-1:0] es, output logic ec);
    int va, vb, r;
    va = bcd2int(ma);
    vb = bcd2int(mb);
    if (!msub) begin
      r  = va + vb + int'(mcin);
      ec = (r >= MOD);
      es = int2bcd(r % MOD);
    end else begin
      r = va - vb - int'(mcin);
      if (r < 0) begin
        ec = 1'b0;
        es = int2bcd(r + MOD);
      end else begin
        ec = 1'b1;
        es = int2bcd(r);
      end
    end
  endtask

  // Drive one operation from an idle/done cycle (called #1 after an edge) and
  // return the outputs seen on the done cycle. lat = cycles from accept to done.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic isub,
                        input logic icin, output logic [W-1:0] osum, output logic ocout,
                        output logic oinv, output int lat, output logic obusy0);
    a = ia; b = ib; mode_sub = isub; cin = icin; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    obusy0 = busy;
    lat    = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    osum  = sum;
    ocout = cout;
    oinv  = invalid;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mode_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    total++;
    if ({busy, done, cout, invalid} !== 4'b0000 || sum !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b sum=%h cout=%b inv=%b, want all 0",
               busy, done, sum, cout, invalid);
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_fixed();
    logic [W-1:0] ta[7], tb_[7], s, es;
    logic tsub[7], tcin[7], co, ec, inv, b0;
    int lat;
    ta[0] = 16'h1234; tb_[0] = 16'h5678; tsub[0] = 0; tcin[0] = 0;
    ta[1] = 16'h9999; tb_[1] = 16'h0001; tsub[1] = 0; tcin[1] = 0;
    ta[2] = 16'h9999; tb_[2] = 16'h0000; tsub[2] = 0; tcin[2] = 1;
    ta[3] = 16'h5000; tb_[3] = 16'h1234; tsub[3] = 1; tcin[3] = 0;
    ta[4] = 16'h1234; tb_[4] = 16'h5000; tsub[4] = 1; tcin[4] = 0;
    ta[5] = 16'h0000; tb_[5] = 16'h0000; tsub[5] = 1; tcin[5] = 1;
    ta[6] = 16'h0500; tb_[6] = 16'h0499; tsub[6] = 1; tcin[6] = 1;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb_[i], tsub[i], tcin[i], s, co, inv, lat, b0);
      model(ta[i], tb_[i], tsub[i], tcin[i], es, ec);
      total++;
      if (lat !== D || b0 !== 1'b1) begin
        bad++;
        $display("FAIL fixed%0d_latency: got lat=%0d busy=%b, want lat=%0d busy=1", i, lat, b0, D);
      end
      total++;
      if (s !== es || co !== ec || inv !== 1'b0) begin
        bad++;
        $display("FAIL fixed%0d_result: got sum=%h cout=%b inv=%b, want sum=%h cout=%b inv=0",
                 i, s, co, inv, es, ec);
      end
      @(posedge clk); #1;
      total++;
      if (done !== 1'b0 || busy !== 1'b0 || sum !== es || cout !== ec) begin
        bad++;
        $display("FAIL fixed%0d_hold: got done=%b busy=%b sum=%h cout=%b, want 0 0 %h %b",
                 i, done, busy, sum, cout, es, ec);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb, s, es;
    logic rs, rc, co, ec, inv, b0;
    int lat;
    for (int i = 0; i < 40; i++) begin
      ra = rand_bcd(); rb = rand_bcd();
      rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
      run_op(ra, rb, rs, rc, s, co, inv, lat, b0);
      model(ra, rb, rs, rc, es, ec);
      total++;
      if (lat !== D || s !== es || co !== ec || inv !== 1'b0) begin
        bad++;
        $display("FAIL random%0d: %h %s %h cin=%b got sum=%h cout=%b inv=%b lat=%0d, want sum=%h cout=%b inv=0 lat=%0d",
                 i, ra, rs ? "-" : "+", rb, rc, s, co, inv, lat, es, ec, D);
      end
    end
    for (int i = 0; i < 10; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      run_op(ra, rb, 1'b0, 1'b0, s, co, inv, lat, b0);
      total++;
      if (inv !== any_bad_digit(ra, rb) || lat !== D) begin
        bad++;
        $display("FAIL random_inv%0d: a=%h b=%h got inv=%b lat=%0d, want inv=%b lat=%0d",
                 i, ra, rb, inv, lat, any_bad_digit(ra, rb), D);
      end
    end
  endtask

  task automatic test_start_held();
    int ndone = 0;
    int nbusy = 0;
    a = 16'h1111; b = 16'h2222; mode_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h9999; b = 16'h9999; mode_sub = 1'b1; cin = 1'b1;
    for (int c = 1; c <= D; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
      if (busy) nbusy++;
    end
    start = 1'b0;
    total++;
    if (ndone !== 1 || done !== 1'b1 || nbusy !== D - 1) begin
      bad++;
      $display("FAIL start_held_seq: got dones=%0d done_at_end=%b busy_cycles=%0d, want 1 1 %0d",
               ndone, done, nbusy, D - 1);
    end
    total++;
    if (sum !== 16'h3333 || cout !== 1'b0) begin
      bad++;
      $display("FAIL start_held_result: got sum=%h cout=%b, want 3333 0", sum, cout);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] s, es;
    logic co, ec, inv, b0;
    int lat;
    run_op(16'h0123, 16'h0456, 1'b0, 1'b0, s, co, inv, lat, b0);
    total++;
    if (s !== 16'h0579 || lat !== D) begin
      bad++;
      $display("FAIL b2b_first: got sum=%h lat=%0d, want 0579 %0d", s, lat, D);
    end
    // Start issued on the done cycle.
    run_op(16'h8765, 16'h4321, 1'b1, 1'b0, s, co, inv, lat, b0);
    model(16'h8765, 16'h4321, 1'b1, 1'b0, es, ec);
    total++;
    if (b0 !== 1'b1 || lat !== D || s !== es || co !== ec) begin
      bad++;
      $display("FAIL b2b_second: got busy=%b lat=%0d sum=%h cout=%b, want 1 %0d %h %b",
               b0, lat, s, co, D, es, ec);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_invalid();
    logic [W-1:0] s;
    logic co, inv, b0;
    int lat;
    int low = 0;
    int c = 0;
    a = 16'h12A4; b = 16'h0001; mode_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (!invalid) low++;
    while (!done && c < 20) begin
      @(posedge clk); #1;
      c++;
      if (!invalid) low++;
    end
    total++;
    if (low !== 0 || c !== D) begin
      bad++;
      $display("FAIL invalid_flag: got cycles_low=%0d lat=%0d, want 0 %0d", low, c, D);
    end
    run_op(16'h0042, 16'h0058, 1'b0, 1'b0, s, co, inv, lat, b0);
    total++;
    if (inv !== 1'b0 || s !== 16'h0100) begin
      bad++;
      $display("FAIL invalid_clear: got inv=%b sum=%h, want 0 0100", inv, s);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_async_reset();
    logic [W-1:0] s;
    logic co, inv, b0;
    int lat;
    int ndone = 0;
    a = 16'h1234; b = 16'h5678; mode_sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (sum !== 16'h0012) begin
      bad++;
      $display("FAIL areset_partial: got sum=%h, want 0012", sum);
    end
    #3 rst = 1'b1;
    #1;
    total++;
    if (busy !== 1'b0 || sum !== '0 || cout !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL areset_immediate: got busy=%b sum=%h cout=%b done=%b, want 0 0 0 0",
               busy, sum, cout, done);
    end
    #2 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    total++;
    if (ndone !== 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL areset_silent: got dones=%0d busy=%b, want 0 0", ndone, busy);
    end
    run_op(16'h1234, 16'h5678, 1'b0, 1'b0, s, co, inv, lat, b0);
    total++;
    if (s !== 16'h6912 || co !== 1'b0 || lat !== D) begin
      bad++;
      $display("FAIL areset_recover: got sum=%h cout=%b lat=%0d, want 6912 0 %0d", s, co, lat, D);
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_random();
    test_start_held();
    test_back_to_back();
    test_invalid();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
